// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and next-PC selector encoding for the IF-stage program counter.
package pc_fetch_unit_pkg;

    localparam logic        RST_ENABLE   = 1'b1;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam int          INST_ADDR_W  = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Which source the PC register loads on the next edge.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_FLUSH,
        SEL_PEND_SET,
        SEL_BRANCH,
        SEL_PEND_TAKE,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: sequential fetch, stall hold, branch and flush redirect,
// with a pending-branch register so a redirect seen under stall is not lost.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = INST_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              ce_o,
    output logic              pc_misaligned_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    pc_sel_e           pc_sel;

    // The enabling edge after reset only raises ce; redirects wait until ce is already 1.
    always_comb begin
        pc_sel = SEL_HOLD;
        if (ce_q != CHIP_ENABLE)        pc_sel = SEL_HOLD;
        else if (flush_i)               pc_sel = SEL_FLUSH;
        else if (stall_i && branch_flag_i) pc_sel = SEL_PEND_SET;
        else if (stall_i)               pc_sel = SEL_HOLD;
        else if (branch_flag_i)         pc_sel = SEL_BRANCH;
        else if (pend_valid_q)          pc_sel = SEL_PEND_TAKE;
        else                            pc_sel = SEL_SEQ;
    end

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        pc_d          = pc_q;
        ce_d          = CHIP_ENABLE;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        unique case (pc_sel)
            SEL_FLUSH: begin
                pc_d         = new_pc_i;
                pend_valid_d = 1'b0;
            end
            SEL_PEND_SET: begin
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target_i;
            end
            SEL_BRANCH: begin
                pc_d         = branch_target_i;
                pend_valid_d = 1'b0;
            end
            SEL_PEND_TAKE: begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end
            SEL_SEQ:  pc_d = pc_q + ADDR_W'(PC_STEP);
            default:  pc_d = pc_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; pend_target is reset
    // too so an unused pending slot never carries X.
    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            ce_q          <= CHIP_DISABLE;
            pc_q          <= ADDR_W'(RESET_PC);
            pend_valid_q  <= 1'b0;
            pend_target_q <= ADDR_W'(ZERO_WORD);
        end else begin
            ce_q          <= ce_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc_o            = pc_q;
    assign inst_addr_o     = {2'b00, pc_q[ADDR_W-1:2]};
    assign ce_o            = ce_q;
    assign pc_misaligned_o = (ce_q == CHIP_ENABLE) && (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, increment, stall, pending branch, flush,
// wrap, misalignment and reset with a pending redirect.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic [31:0] inst_addr_o;
    logic        ce_o;
    logic        pc_misaligned_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .pc_o            (pc_o),
        .inst_addr_o     (inst_addr_o),
        .ce_o            (ce_o),
        .pc_misaligned_o (pc_misaligned_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and let outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input string tag, input logic [31:0] exp_pc);
        check({tag, ".pc"}, pc_o, exp_pc);
        check({tag, ".inst_addr"}, inst_addr_o, {2'b00, exp_pc[31:2]});
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = '0;
        branch_flag_i = 1'b0; branch_target_i = '0;

        // Reset release and sequential fetch
        repeat (3) tick();
        check("rst.ce", {31'd0, ce_o}, 32'd0);
        check("rst.pc", pc_o, 32'h0);
        check("rst.mis", {31'd0, pc_misaligned_o}, 32'd0);
        rst_i = 1'b0;
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0700;
        tick();
        check("en.ce", {31'd0, ce_o}, 32'd1);
        expect_pc("en", 32'h0);
        branch_flag_i = 1'b0;
        tick(); expect_pc("seq1", 32'h4);
        tick(); expect_pc("seq2", 32'h8);
        tick(); expect_pc("seq3", 32'hC);
        tick(); expect_pc("seq4", 32'h10);

        // Stall hold
        stall_i = 1'b1;
        tick(); expect_pc("stall1", 32'h10);
        tick(); expect_pc("stall2", 32'h10);
        stall_i = 1'b0;
        tick(); expect_pc("resume", 32'h14);
        tick(); tick(); tick(); expect_pc("pre_br", 32'h20);

        // Branch arriving during stall is held until release
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h100;
        tick(); expect_pc("pend1", 32'h20);
        branch_flag_i = 1'b0;
        tick(); expect_pc("pend2", 32'h20);
        stall_i = 1'b0;
        tick(); expect_pc("pend_take", 32'h100);
        tick(); expect_pc("pend_next", 32'h104);

        // Flush beats stall and branch, and cancels the branch
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200;
        flush_i = 1'b1; new_pc_i = 32'h180;
        tick(); expect_pc("flush", 32'h180);
        flush_i = 1'b0; branch_flag_i = 1'b0;
        tick(); expect_pc("flush_hold", 32'h180);
        stall_i = 1'b0;
        tick(); expect_pc("flush_seq1", 32'h184);
        tick(); expect_pc("flush_seq2", 32'h188);

        // Wrap at top of address space
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        tick(); expect_pc("top", 32'hFFFF_FFFC);
        branch_flag_i = 1'b0;
        tick(); expect_pc("wrap", 32'h0);

        // Misaligned target is loaded and incremented unchanged
        branch_flag_i = 1'b1; branch_target_i = 32'h42;
        tick(); expect_pc("mis_ld", 32'h42);
        check("mis_ld.flag", {31'd0, pc_misaligned_o}, 32'd1);
        branch_flag_i = 1'b0;
        tick(); expect_pc("mis_inc", 32'h46);
        check("mis_inc.flag", {31'd0, pc_misaligned_o}, 32'd1);
        flush_i = 1'b1; new_pc_i = 32'h48;
        tick(); expect_pc("recover", 32'h48);
        check("recover.flag", {31'd0, pc_misaligned_o}, 32'd0);
        flush_i = 1'b0;

        // Reset discards a pending redirect and overrides flush
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h300;
        tick(); expect_pc("pend300", 32'h48);
        branch_flag_i = 1'b0; rst_i = 1'b1; flush_i = 1'b1; new_pc_i = 32'h500;
        tick();
        check("mid_rst.ce", {31'd0, ce_o}, 32'd0);
        check("mid_rst.pc", pc_o, 32'h0);
        check("mid_rst.mis", {31'd0, pc_misaligned_o}, 32'd0);
        rst_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        tick();
        check("re_en.ce", {31'd0, ce_o}, 32'd1);
        expect_pc("re_en", 32'h0);
        tick(); expect_pc("re_seq1", 32'h4);
        tick(); expect_pc("re_seq2", 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
